vector_scan_encoder: RTL and testbench

//  Sequential consumer of the lowest-set-bit detector: accepts a request vector,

---
 rtl/vector_scan_encoder.sv | 91 +++++++++
 tb/tb_vector_scan_encoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_scan_encoder.sv
// Pops set bits of a request vector one per output handshake, LSB first, and emits each index.
// Optional macro VECTOR_SCAN_BYPASS_EN: accept the next vector on the same edge the last bit pops.
module vector_scan_encoder #(
  parameter int unsigned VECTOR_WIDTH = 16,
  localparam int unsigned IDX_WIDTH = $clog2(VECTOR_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [VECTOR_WIDTH-1:0] in_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_WIDTH-1:0]    out_idx,
  output logic                    out_last,
  output logic                    busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  localparam logic [VECTOR_WIDTH-1:0] ONE = VECTOR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [VECTOR_WIDTH-1:0] pending_q, pending_d;

  logic [VECTOR_WIDTH-1:0] low_bit;
  logic [VECTOR_WIDTH-1:0] rest;
  logic [IDX_WIDTH-1:0]    enc_idx;
  logic                    single;
  logic                    fire;
  logic                    load;

  // Lowest-set-bit isolation and one-hot to binary encode
  always_comb begin
    low_bit = pending_q & (~pending_q + ONE);
    rest    = pending_q & (pending_q - ONE);
    single  = (pending_q != '0) && (rest == '0);
    enc_idx = '0;
    for (int unsigned i = 0; i < VECTOR_WIDTH; i++) begin
      if (low_bit[i]) begin
        enc_idx = enc_idx | IDX_WIDTH'(i);
      end
    end
  end

  // Handshakes are masked while rst is high so no transfer is reported during reset
  always_comb begin
    out_valid = !rst && (state_q == S_DRAIN);
    fire      = out_valid && out_ready;
`ifdef VECTOR_SCAN_BYPASS_EN
    in_ready  = !rst && ((state_q == S_IDLE) || (fire && single));
`else
    in_ready  = !rst && (state_q == S_IDLE);
`endif
    load      = in_valid && in_ready;
    out_idx   = out_valid ? enc_idx : '0;
    out_last  = out_valid && single;
    busy      = (pending_q != '0);
  end

  // Next-state: pop on fire, a load overrides (bypass case: last bit popped same edge)
  always_comb begin
    pending_d = pending_q;
    state_d   = state_q;
    if (fire) begin
      pending_d = rest;
    end
    if (load) begin
      pending_d = in_vec;
    end
    case (state_q)
      S_IDLE:  state_d = (pending_d != '0) ? S_DRAIN : S_IDLE;
      S_DRAIN: state_d = (pending_d != '0) ? S_DRAIN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_vector_scan_encoder.sv
// Directed self-checking bench for vector_scan_encoder (VECTOR_WIDTH=16).
module tb_vector_scan_encoder;

  localparam int unsigned VW = 16;
  localparam int unsigned IW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_vec;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;

  int tests;
  int failed;

  vector_scan_encoder #(.VECTOR_WIDTH(VW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_idx;
    int expect_seq[4];
    tests     = 0;
    failed    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;

    // 1: reset held three cycles, then released
    #1;
    chk("rst_in_ready_pre", 32'(in_ready), 32'd0);
    chk("rst_out_valid_pre", 32'(out_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_out_valid", 32'(out_valid), 32'd0);

    // 2: 16'h8421 with out_ready held high
    expect_seq[0] = 0; expect_seq[1] = 5; expect_seq[2] = 10; expect_seq[3] = 15;
    in_vec    = 16'h8421;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t2_in_ready_load", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_vec   = '0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_out_valid", 32'(out_valid), 32'd1);
      chk("t2_out_idx", 32'(out_idx), 32'(expect_seq[k]));
      chk("t2_out_last", 32'(out_last), (k == 3) ? 32'd1 : 32'd0);
      chk("t2_busy", 32'(busy), 32'd1);
`ifdef VECTOR_SCAN_BYPASS_EN
      chk("t2_in_ready_drain", 32'(in_ready), (k == 3) ? 32'd1 : 32'd0);
`else
      chk("t2_in_ready_drain", 32'(in_ready), 32'd0);
`endif
      tick();
    end
    chk("t2_done_out_valid", 32'(out_valid), 32'd0);
    chk("t2_done_in_ready", 32'(in_ready), 32'd1);
    chk("t2_done_busy", 32'(busy), 32'd0);

    // 3: all ones with a pseudo-random out_ready; every stalled cycle must hold idx/last
    in_vec    = 16'hFFFF;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_vec   = '0;
    exp_idx  = 0;
    for (int c = 0; c < 200 && exp_idx < 16; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("t3_out_valid", 32'(out_valid), 32'd1);
      chk("t3_out_idx", 32'(out_idx), 32'(exp_idx));
      chk("t3_out_last", 32'(out_last), (exp_idx == 15) ? 32'd1 : 32'd0);
      if (out_ready) exp_idx++;
      tick();
    end
    chk("t3_pop_count", 32'(exp_idx), 32'd16);
    out_ready = 1'b1;
    #1;
    chk("t3_done_out_valid", 32'(out_valid), 32'd0);
    chk("t3_done_busy", 32'(busy), 32'd0);
    chk("t3_done_in_ready", 32'(in_ready), 32'd1);

    // 4: zero vector is accepted and dropped
    in_vec   = 16'h0000;
    in_valid = 1'b1;
    #1;
    chk("t4_in_ready_load", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t4_out_valid_2", 32'(out_valid), 32'd0);

    // 5: reset in the middle of a drain discards the remaining bits
    in_vec   = 16'h00F0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_vec   = '0;
    #1;
    chk("t5_idx4", 32'(out_idx), 32'd4);
    chk("t5_valid4", 32'(out_valid), 32'd1);
    tick();
    chk("t5_idx5", 32'(out_idx), 32'd5);
    chk("t5_valid5", 32'(out_valid), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_rel_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rel_in_ready", 32'(in_ready), 32'd1);
    chk("t5_rel_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_no_more_out", 32'(out_valid), 32'd0);
    end

    // 6: two vectors offered back to back
    in_vec   = 16'h0003;
    in_valid = 1'b1;
    tick();
    in_vec = 16'h8000;
    #1;
    chk("t6_idx0", 32'(out_idx), 32'd0);
    chk("t6_valid0", 32'(out_valid), 32'd1);
    chk("t6_last0", 32'(out_last), 32'd0);
    chk("t6_in_ready0", 32'(in_ready), 32'd0);
    tick();
    chk("t6_idx1", 32'(out_idx), 32'd1);
    chk("t6_valid1", 32'(out_valid), 32'd1);
    chk("t6_last1", 32'(out_last), 32'd1);
`ifdef VECTOR_SCAN_BYPASS_EN
    chk("t6_in_ready1", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_vec   = '0;
    #1;
`else
    chk("t6_in_ready1", 32'(in_ready), 32'd0);
    tick();
    chk("t6_bubble_valid", 32'(out_valid), 32'd0);
    chk("t6_bubble_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_vec   = '0;
    #1;
`endif
    chk("t6_idx15", 32'(out_idx), 32'd15);
    chk("t6_valid15", 32'(out_valid), 32'd1);
    chk("t6_last15", 32'(out_last), 32'd1);
    tick();
    chk("t6_done_valid", 32'(out_valid), 32'd0);
    chk("t6_done_in_ready", 32'(in_ready), 32'd1);
    chk("t6_done_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
